svc_rv_dmem_resp: RTL and testbench

SVC_RV_DMEM_RESP -- requirements
Module: svc_rv_dmem_resp

---
 rtl/svc_rv_dmem_resp.sv | 104 ++++++++++
 tb/tb_svc_rv_dmem_resp.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_rv_dmem_resp.sv
// Data-memory responder for an RV core: word-addressed 32-bit memory with
// byte strobes, selectable combinational/registered read timing, and a
// stall generator (directed request ORed with an LFSR) capped at MAX_STALL.
module svc_rv_dmem_resp #(
  parameter int          AW        = 8,
  parameter int          MEM_TYPE  = 1,
  parameter int          STALL_EN  = 1,
  parameter int          MAX_STALL = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dmem_ren,
  input  logic [31:0] dmem_raddr,
  output logic [31:0] dmem_rdata,
  input  logic        dmem_we,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_stall,
  input  logic        stall_req,
  output logic [31:0] stall_cycles
);

  localparam int          DEPTH       = 2 ** AW;
  localparam logic [1:0]  MAX_STALL_C = 2'(MAX_STALL);
  localparam logic        STALL_EN_C  = (STALL_EN != 0);

  // Galois right-shift step, feedback mask for taps 16,14,13,11
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  logic [31:0]   mem [DEPTH];
  logic [15:0]   lfsr_q, lfsr_d;
  logic [1:0]    stall_cnt_q, stall_cnt_d;
  logic [31:0]   stall_cycles_q, stall_cycles_d;
  logic [AW-1:0] ridx, widx;
  logic          req, rand_stall, wr_en;
  logic          unused_addr;

  // Upper address bits wrap (aliasing) and byte offsets are ignored
  assign ridx        = dmem_raddr[AW+1:2];
  assign widx        = dmem_waddr[AW+1:2];
  assign unused_addr = ^{dmem_raddr[31:AW+2], dmem_raddr[1:0],
                         dmem_waddr[31:AW+2], dmem_waddr[1:0]};

  assign req        = dmem_ren | dmem_we;
  assign rand_stall = lfsr_q[0] & lfsr_q[3];
  assign dmem_stall = STALL_EN_C & req & (stall_req | rand_stall)
                      & (stall_cnt_q < MAX_STALL_C);
  assign wr_en      = dmem_we & ~dmem_stall;

  // Next-state for the stall generator and stall statistics
  always_comb begin
    lfsr_d         = lfsr_step(lfsr_q);
    stall_cnt_d    = dmem_stall ? (stall_cnt_q + 2'd1) : 2'd0;
    stall_cycles_d = dmem_stall ? (stall_cycles_q + 32'd1) : stall_cycles_q;
  end

  // Control state: LFSR, consecutive-stall counter, stall-cycle counter
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q         <= LFSR_SEED;
      stall_cnt_q    <= 2'd0;
      stall_cycles_q <= 32'd0;
    end else begin
      lfsr_q         <= lfsr_d;
      stall_cnt_q    <= stall_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

  // Byte-strobed write; memory is data, so reset leaves it untouched
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_wstrb[b]) mem[widx][8*b +: 8] <= dmem_wdata[8*b +: 8];
      end
    end
  end

  generate
    if (MEM_TYPE == 0) begin : g_comb_read
      assign dmem_rdata = dmem_ren ? mem[ridx] : 32'd0;
    end else begin : g_reg_read
      logic [31:0] rdata_q;

      // Registered read, read-first against a same-edge write; holds while stalled
      always_ff @(posedge clock) begin
        if (reset) begin
          rdata_q <= 32'd0;
        end else if (dmem_ren && !dmem_stall) begin
          rdata_q <= mem[ridx];
        end
      end

      assign dmem_rdata = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_svc_rv_dmem_resp.sv
// Bench for svc_rv_dmem_resp: three instances share one request bus
// (no-stall registered, stalling registered, no-stall combinational).
module tb_svc_rv_dmem_resp;

  logic        clock, reset;
  logic        ren, we, sreq;
  logic [31:0] raddr, waddr, wdata;
  logic [3:0]  wstrb;
  logic [31:0] rd_ns, rd_st, rd_c, sc_ns, sc_st, sc_c;
  logic        st_ns, st_st, st_c;

  int tests = 0;
  int fails = 0;

  svc_rv_dmem_resp #(.AW(8), .MEM_TYPE(1), .STALL_EN(0)) u_ns (
    .clock(clock), .reset(reset), .dmem_ren(ren), .dmem_raddr(raddr),
    .dmem_rdata(rd_ns), .dmem_we(we), .dmem_waddr(waddr), .dmem_wdata(wdata),
    .dmem_wstrb(wstrb), .dmem_stall(st_ns), .stall_req(sreq), .stall_cycles(sc_ns));

  svc_rv_dmem_resp #(.AW(8), .MEM_TYPE(1), .STALL_EN(1), .MAX_STALL(2)) u_st (
    .clock(clock), .reset(reset), .dmem_ren(ren), .dmem_raddr(raddr),
    .dmem_rdata(rd_st), .dmem_we(we), .dmem_waddr(waddr), .dmem_wdata(wdata),
    .dmem_wstrb(wstrb), .dmem_stall(st_st), .stall_req(sreq), .stall_cycles(sc_st));

  svc_rv_dmem_resp #(.AW(8), .MEM_TYPE(0), .STALL_EN(0)) u_c (
    .clock(clock), .reset(reset), .dmem_ren(ren), .dmem_raddr(raddr),
    .dmem_rdata(rd_c), .dmem_we(we), .dmem_waddr(waddr), .dmem_wdata(wdata),
    .dmem_wstrb(wstrb), .dmem_stall(st_c), .stall_req(sreq), .stall_cycles(sc_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference stall generator for the stalling instance
  logic [15:0] m_lfsr;
  logic [1:0]  m_cnt;
  logic [31:0] m_scyc;
  logic        exp_stall;

  always_comb exp_stall = (ren | we) & (sreq | (m_lfsr[0] & m_lfsr[3])) & (m_cnt < 2'd2);

  always @(posedge clock) begin
    if (reset) begin
      m_lfsr <= 16'hACE1;
      m_cnt  <= 2'd0;
      m_scyc <= 32'd0;
    end else begin
      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      m_cnt  <= exp_stall ? m_cnt + 2'd1 : 2'd0;
      m_scyc <= exp_stall ? m_scyc + 32'd1 : m_scyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; ren = 1'b0; waddr = '0; raddr = '0; wdata = '0; wstrb = '0;
  endtask

  // Present a request on the stalling instance and hold it until accepted
  task automatic hs(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                    input logic [3:0] ws, input logic r, input logic [31:0] ra,
                    input logic sr, output int nstall);
    logic done;
    we = w; waddr = wa; wdata = wd; wstrb = ws; ren = r; raddr = ra; sreq = sr;
    nstall = 0;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      #1;
      if (!st_st) done = 1'b1;
      else nstall++;
      cyc();
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL hs_timeout: still stalled after 8 cycles, required accept");
    end
    idle();
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ren;
    logic [31:0] raddr;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                              input logic [3:0] ws, input logic r, input logic [31:0] ra,
                              input logic c, input logic [31:0] e);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.wstrb = ws;
    v.ren = r; v.raddr = ra; v.chk = c; v.exp = e;
    return v;
  endfunction

  vec_t        tv [16];
  logic [31:0] m_mem [16];

  initial begin
    int          ns;
    logic [31:0] v, prev_rd, exp_rd;
    logic        s, hold;
    int          run, ri, wi;

    tv[0]  = mk(1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 32'h0,   0, 32'h0);
    tv[1]  = mk(0, 32'h0,   32'h0,        4'h0, 1, 32'h10,  1, 32'hDEADBEEF);
    tv[2]  = mk(1, 32'h20,  32'h11223344, 4'hF, 0, 32'h0,   0, 32'h0);
    tv[3]  = mk(1, 32'h20,  32'hAABBCCDD, 4'h5, 0, 32'h0,   0, 32'h0);
    tv[4]  = mk(0, 32'h0,   32'h0,        4'h0, 1, 32'h20,  1, 32'h11BB33DD);
    tv[5]  = mk(1, 32'h000, 32'hCAFE0001, 4'hF, 0, 32'h0,   0, 32'h0);
    tv[6]  = mk(0, 32'h0,   32'h0,        4'h0, 1, 32'h400, 1, 32'hCAFE0001);
    tv[7]  = mk(1, 32'h24,  32'h01020304, 4'hF, 0, 32'h0,   0, 32'h0);
    tv[8]  = mk(1, 32'h24,  32'hFFFFFFFF, 4'h0, 0, 32'h0,   0, 32'h0);
    tv[9]  = mk(0, 32'h0,   32'h0,        4'h0, 1, 32'h24,  1, 32'h01020304);
    tv[10] = mk(1, 32'h30,  32'hA5A5A5A5, 4'hF, 0, 32'h0,   0, 32'h0);
    tv[11] = mk(1, 32'h30,  32'h5A5A5A5A, 4'hF, 1, 32'h30,  1, 32'hA5A5A5A5);
    tv[12] = mk(0, 32'h0,   32'h0,        4'h0, 1, 32'h30,  1, 32'h5A5A5A5A);
    tv[13] = mk(0, 32'h0,   32'h0,        4'h0, 0, 32'h0,   1, 32'h5A5A5A5A);
    tv[14] = mk(1, 32'h10,  32'h77000000, 4'h8, 0, 32'h0,   0, 32'h0);
    tv[15] = mk(0, 32'h0,   32'h0,        4'h0, 1, 32'h13,  1, 32'h77ADBEEF);

    // Reset state
    reset = 1'b1; sreq = 1'b0;
    idle();
    repeat (2) cyc();
    chk("rst_rdata_ns", rd_ns, 32'h0);
    chk("rst_rdata_st", rd_st, 32'h0);
    chk("rst_stall_cycles", sc_st, 32'h0);
    sreq = 1'b1;
    #1;
    chk("noreq_stall", {31'h0, st_st}, 32'h0);
    reset = 1'b0;
    cyc();

    // Table: functional vectors on the non-stalling instances
    for (int i = 0; i < 16; i++) begin
      we = tv[i].we; waddr = tv[i].waddr; wdata = tv[i].wdata; wstrb = tv[i].wstrb;
      ren = tv[i].ren; raddr = tv[i].raddr;
      #1;
      chk($sformatf("comb_rdata[%0d]", i), rd_c, tv[i].ren ? tv[i].exp : 32'h0);
      chk($sformatf("ns_stall[%0d]", i), {30'h0, st_ns, st_c}, 32'h0);
      cyc();
      if (tv[i].chk) chk($sformatf("reg_rdata[%0d]", i), rd_ns, tv[i].exp);
    end
    idle();
    sreq = 1'b0;

    // Directed stall: high 2, low 1, high 2
    reset = 1'b1;
    cyc();
    reset = 1'b0; ren = 1'b1; raddr = 32'h10; sreq = 1'b1;
    v = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("pat_stall[%0d]", k), {31'h0, st_st}, (k == 2) ? 32'h0 : 32'h1);
      if (k < 2) chk($sformatf("pat_hold0[%0d]", k), rd_st, 32'h0);
      if (k == 3) v = rd_st;
      if (k == 4) chk("pat_hold4", rd_st, v);
      cyc();
    end
    chk("pat_hold_end", rd_st, v);
    chk("pat_stall_cycles", sc_st, 32'd4);
    idle();
    sreq = 1'b0;
    cyc();

    // Stalled write must not modify memory
    hs(1, 32'h40, 32'h11, 4'hF, 0, 32'h0, 0, ns);
    we = 1'b1; waddr = 32'h40; wdata = 32'h55; wstrb = 4'hF; sreq = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("sw_stall[%0d]", k), {31'h0, st_st}, 32'h1);
      cyc();
    end
    idle();
    sreq = 1'b0;
    hs(0, 32'h0, 32'h0, 4'h0, 1, 32'h40, 0, ns);
    chk("sw_unchanged", rd_st, 32'h11);
    hs(1, 32'h40, 32'h55, 4'hF, 0, 32'h0, 1, ns);
    chk("sw_nstall", ns, 32'd2);
    hs(0, 32'h0, 32'h0, 4'h0, 1, 32'h40, 0, ns);
    chk("sw_committed", rd_st, 32'h55);

    // Reset mid-stall clears the run counter; memory survives reset
    ren = 1'b1; raddr = 32'h40; sreq = 1'b1;
    #1;
    chk("rms_stall0", {31'h0, st_st}, 32'h1);
    cyc();
    reset = 1'b1;
    #1;
    chk("rms_stall_rst", {31'h0, st_st}, 32'h1);
    cyc();
    reset = 1'b0;
    chk("rms_cycles", sc_st, 32'h0);
    chk("rms_rdata", rd_st, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("rms_stall[%0d]", k), {31'h0, st_st}, (k < 2) ? 32'h1 : 32'h0);
      cyc();
    end
    chk("rms_mem_st", rd_st, 32'h55);
    chk("rms_mem_ns", rd_ns, 32'h55);
    idle();
    sreq = 1'b0;
    cyc();

    // Random stalls against a memory model on 16 words
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = $urandom;
      hs(1, 32'h80 + 32'(4 * i), m_mem[i], 4'hF, 0, 32'h0, 0, ns);
    end
    hold = 1'b0; run = 0; ri = 0; wi = 0;
    for (int c = 0; c < 1000; c++) begin
      if (!hold) begin
        int kind;
        kind = $urandom_range(0, 3);
        ri = $urandom_range(0, 15);
        wi = $urandom_range(0, 15);
        ren   = (kind == 1) || (kind == 3);
        we    = (kind == 2) || (kind == 3);
        raddr = (32'h80 + 32'(4 * ri)) | ($urandom & 32'hFFFF_FC03);
        waddr = (32'h80 + 32'(4 * wi)) | ($urandom & 32'hFFFF_FC03);
        wdata = $urandom;
        wstrb = 4'($urandom_range(0, 15));
        sreq  = ($urandom_range(0, 3) == 0);
      end
      #1;
      s = st_st;
      chk("rnd_stall", {31'h0, s}, {31'h0, exp_stall});
      run = s ? run + 1 : 0;
      chk("rnd_run", {31'h0, run > 2}, 32'h0);
      prev_rd = rd_st;
      exp_rd  = m_mem[ri];
      if (!s && we) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) m_mem[wi][8*b +: 8] = wdata[8*b +: 8];
      end
      cyc();
      if (s || !ren) chk("rnd_hold", rd_st, prev_rd);
      else chk("rnd_read", rd_st, exp_rd);
      hold = s;
    end
    idle();
    sreq = 1'b0;
    cyc();
    chk("final_stall_cycles", sc_st, m_scyc);
    chk("final_ns_cycles", sc_ns | sc_c, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
